// File: rtl/sram_param_pkg.sv
// Shared types and helpers for the parametrised 1RW + N-read SRAM model.
// Holds the clear/ready state encoding, collision policy codes and write-lane sizing.
package sram_param_pkg;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } sram_state_e;

    localparam int COLL_OLD           = 0;
    localparam int COLL_WRITE_THROUGH = 1;

    // Lane count; zero flags a width that does not split evenly into lanes.
    function automatic int calc_num_wmasks(input int data_width, input int write_size);
        if ((write_size > 0) && ((data_width % write_size) == 0)) begin
            return data_width / write_size;
        end else begin
            return 0;
        end
    endfunction

endpackage

// File: rtl/sram_rd_port.sv
// One read-only port: registered data, valid strobe and collision flag.
// In write-through mode the masked lanes of a same-address write are merged in.
module sram_rd_port
    import sram_param_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int WRITE_SIZE     = 8,
    parameter int NUM_WMASKS     = 4,
    parameter int COLLISION_MODE = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic [DATA_WIDTH-1:0] word_i,
    input  logic                  hit_i,
    input  logic [NUM_WMASKS-1:0] wmask_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] dout_o,
    output logic                  valid_o,
    output logic                  collision_o
);

    logic [DATA_WIDTH-1:0] merged_s;
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  valid_q;
    logic                  collision_q;

    // word_i is the pre-edge array content, so old-data mode needs no merge at all
    always_comb begin
        merged_s = word_i;
        for (int i = 0; i < NUM_WMASKS; i++) begin
            if ((COLLISION_MODE == COLL_WRITE_THROUGH) && hit_i && wmask_i[i]) begin
                merged_s[i*WRITE_SIZE +: WRITE_SIZE] = wdata_i[i*WRITE_SIZE +: WRITE_SIZE];
            end else begin
                merged_s[i*WRITE_SIZE +: WRITE_SIZE] = word_i[i*WRITE_SIZE +: WRITE_SIZE];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dout_q      <= '0;
            valid_q     <= 1'b0;
            collision_q <= 1'b0;
        end else if (en_i) begin
            dout_q      <= merged_s;
            valid_q     <= 1'b1;
            collision_q <= hit_i;
        end else begin
            valid_q     <= 1'b0;
            collision_q <= 1'b0;
        end
    end

    assign dout_o      = dout_q;
    assign valid_o     = valid_q;
    assign collision_o = collision_q;

endmodule

// File: rtl/sram_1rwnr_param.sv
// Parametrised SRAM stand-in: one read/write port, NUM_RPORTS read ports, single clock.
// Owns the array, port 0 and the optional zero-fill sequencer that runs after reset.
module sram_1rwnr_param
    import sram_param_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 8,
    parameter int WRITE_SIZE     = 8,
    parameter int NUM_RPORTS     = 1,
    parameter int CLEAR_ON_RESET = 1,
    parameter int COLLISION_MODE = 0,
    localparam int NUM_WMASKS    = calc_num_wmasks(DATA_WIDTH, WRITE_SIZE)
) (
    input  logic                             clk0,
    input  logic                             rst0,
    output logic                             init_done,
    input  logic                             csb0,
    input  logic                             web0,
    input  logic [NUM_WMASKS-1:0]            wmask0,
    input  logic [ADDR_WIDTH-1:0]            addr0,
    input  logic [DATA_WIDTH-1:0]            din0,
    output logic [DATA_WIDTH-1:0]            dout0,
    output logic                             dout0_valid,
    input  logic [NUM_RPORTS-1:0]            csb1,
    input  logic [NUM_RPORTS*ADDR_WIDTH-1:0] addr1,
    output logic [NUM_RPORTS*DATA_WIDTH-1:0] dout1,
    output logic [NUM_RPORTS-1:0]            dout1_valid,
    output logic [NUM_RPORTS-1:0]            collision
);

    localparam int          RAM_DEPTH = 1 << ADDR_WIDTH;
    localparam sram_state_e RST_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : READY;

    if (NUM_WMASKS == 0) begin : g_bad_wmask
        $error("sram_1rwnr_param: DATA_WIDTH must be a multiple of WRITE_SIZE");
    end
    if ((NUM_RPORTS < 1) || (NUM_RPORTS > 4)) begin : g_bad_rports
        $error("sram_1rwnr_param: NUM_RPORTS must be in 1..4");
    end

    logic [DATA_WIDTH-1:0] mem_q [RAM_DEPTH];

    sram_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  init_done_q;
    logic [DATA_WIDTH-1:0] dout0_q;
    logic                  dout0_valid_q;

    logic clr_we_s;
    logic accept_s;
    logic p0_rd_s;
    logic p0_wr_s;

    // Next-state for the zero-fill sequencer
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        clr_we_s = 1'b0;
        case (state_q)
            CLEAR: begin
                clr_we_s = ~rst0;
                cnt_d    = cnt_q + ADDR_WIDTH'(1);
                if (cnt_q == ADDR_WIDTH'(RAM_DEPTH - 1)) begin
                    state_d = READY;
                end else begin
                    state_d = CLEAR;
                end
            end
            READY: begin
                state_d = READY;
            end
            default: begin
                state_d = RST_STATE;
            end
        endcase
    end

    always_ff @(posedge clk0) begin
        if (rst0) begin
            state_q     <= RST_STATE;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= (state_d == READY);
        end
    end

    assign accept_s = (state_q == READY) && !rst0;
    assign p0_rd_s  = accept_s && !csb0 && web0;
    assign p0_wr_s  = accept_s && !csb0 && !web0;

    // Array update: clear sweep has priority, then lane-masked port 0 write
    always_ff @(posedge clk0) begin
        if (clr_we_s) begin
            mem_q[cnt_q] <= '0;
        end else if (p0_wr_s) begin
            for (int i = 0; i < NUM_WMASKS; i++) begin
                if (wmask0[i]) begin
                    mem_q[addr0][i*WRITE_SIZE +: WRITE_SIZE] <= din0[i*WRITE_SIZE +: WRITE_SIZE];
                end
            end
        end
    end

    always_ff @(posedge clk0) begin
        if (rst0) begin
            dout0_q       <= '0;
            dout0_valid_q <= 1'b0;
        end else if (p0_rd_s) begin
            dout0_q       <= mem_q[addr0];
            dout0_valid_q <= 1'b1;
        end else begin
            dout0_valid_q <= 1'b0;
        end
    end

    assign init_done   = init_done_q;
    assign dout0       = dout0_q;
    assign dout0_valid = dout0_valid_q;

    for (genvar k = 0; k < NUM_RPORTS; k++) begin : g_rd
        logic [ADDR_WIDTH-1:0] raddr_s;
        logic [DATA_WIDTH-1:0] rword_s;
        logic                  hit_s;

        assign raddr_s = addr1[k*ADDR_WIDTH +: ADDR_WIDTH];
        assign rword_s = mem_q[raddr_s];
        assign hit_s   = p0_wr_s && (addr0 == raddr_s);

        sram_rd_port #(
            .DATA_WIDTH     (DATA_WIDTH),
            .WRITE_SIZE     (WRITE_SIZE),
            .NUM_WMASKS     (NUM_WMASKS),
            .COLLISION_MODE (COLLISION_MODE)
        ) u_rd (
            .clk_i       (clk0),
            .rst_i       (rst0),
            .en_i        (accept_s && !csb1[k]),
            .word_i      (rword_s),
            .hit_i       (hit_s),
            .wmask_i     (wmask0),
            .wdata_i     (din0),
            .dout_o      (dout1[k*DATA_WIDTH +: DATA_WIDTH]),
            .valid_o     (dout1_valid[k]),
            .collision_o (collision[k])
        );
    end

endmodule
